// File: rtl/core_run_pkg.sv
// Shared definitions for the piRISC run controller: FSM encoding, default
// halt sentinel and sizing of the reset/go-delay phase counter.
package core_run_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RST  = 3'd1,
    WAIT = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } run_state_t;

  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  // The phase counter walks 0..span-1 for the longer of the two phases.
  function automatic int phase_cnt_w(input int reset_cycles, input int go_delay);
    int span;
    span = (reset_cycles > go_delay) ? reset_cycles : go_delay;
    return (span <= 1) ? 1 : $clog2(span);
  endfunction

endpackage

// File: rtl/halt_detect.sv
// Per-core halt detector: flags the core as halted the first time its IR
// shows the sentinel while enabled, and holds that flag until cleared.
module halt_detect
  import core_run_pkg::*;
#(
  parameter int              IR_W      = 32,
  parameter logic [IR_W-1:0] HALT_WORD = IR_W'(DEFAULT_HALT_WORD)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            clr,
  input  logic [IR_W-1:0] lane,
  output logic            halted,
  output logic            hit
);

  // hit is the halt being recorded on the coming edge; the controller needs
  // it to decide completion on the same edge.
  assign hit = en && !halted && (lane == HALT_WORD);

  always_ff @(posedge clk) begin
    if (reset) begin
      halted <= 1'b0;
    end else if (clr) begin
      halted <= 1'b0;
    end else if (hit) begin
      halted <= 1'b1;
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller for N piRISC cores: reset pulse, delayed go, per-core halt
// detection on the sentinel IR, and a RUN-cycle watchdog.
module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int              N_CORES        = 1,
  parameter int              IR_W           = 32,
  parameter logic [IR_W-1:0] HALT_WORD      = IR_W'(DEFAULT_HALT_WORD),
  parameter int              RESET_CYCLES   = 1,
  parameter int              GO_DELAY       = 1,
  parameter int              TIMEOUT_CYCLES = 1500,
  parameter int              CNT_W          = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [N_CORES*IR_W-1:0] ir_in,
  output logic                    core_reset,
  output logic [N_CORES-1:0]      go_contr,
  output logic [N_CORES-1:0]      halted,
  output logic                    busy,
  output logic                    done,
  output logic                    timed_out,
  output logic [CNT_W-1:0]        cycle_count
);

  localparam int               PH_W         = phase_cnt_w(RESET_CYCLES, GO_DELAY);
  localparam logic [PH_W-1:0]  RST_LAST     = PH_W'(RESET_CYCLES - 1);
  localparam logic [PH_W-1:0]  WAIT_LAST    = PH_W'((GO_DELAY > 0) ? GO_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  run_state_t         state;
  run_state_t         state_next;
  logic [PH_W-1:0]    phase_cnt;
  logic               phase_clr;
  logic               phase_inc;
  logic               launch;
  logic               cnt_inc;
  logic               fire_timeout;
  logic               run_en;
  logic [N_CORES-1:0] hit;
  logic               all_halted_next;

  assign run_en = (state == RUN);

  for (genvar i = 0; i < N_CORES; i++) begin : g_core
    halt_detect #(
      .IR_W      (IR_W),
      .HALT_WORD (HALT_WORD)
    ) u_halt (
      .clk    (clk),
      .reset  (reset),
      .en     (run_en),
      .clr    (launch),
      .lane   (ir_in[i*IR_W +: IR_W]),
      .halted (halted[i]),
      .hit    (hit[i])
    );
  end

  // Completion counts halts landing on this very edge, so a halt coinciding
  // with the watchdog edge wins over the timeout.
  assign all_halted_next = &(halted | hit);

  always_comb begin
    state_next   = state;
    phase_clr    = 1'b0;
    phase_inc    = 1'b0;
    launch       = 1'b0;
    cnt_inc      = 1'b0;
    fire_timeout = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RST;
          launch     = 1'b1;
          phase_clr  = 1'b1;
        end
      end
      RST: begin
        if (phase_cnt == RST_LAST) begin
          phase_clr  = 1'b1;
          state_next = (GO_DELAY == 0) ? RUN : WAIT;
        end else begin
          phase_inc = 1'b1;
        end
      end
      WAIT: begin
        if (phase_cnt == WAIT_LAST) begin
          phase_clr  = 1'b1;
          state_next = RUN;
        end else begin
          phase_inc = 1'b1;
        end
      end
      RUN: begin
        cnt_inc = 1'b1;
        if (all_halted_next) begin
          state_next = DONE;
        end else if (cycle_count == TIMEOUT_LAST) begin
          state_next   = DONE;
          fire_timeout = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      cycle_count <= '0;
      timed_out   <= 1'b0;
    end else begin
      state <= state_next;
      if (phase_clr) begin
        phase_cnt <= '0;
      end else if (phase_inc) begin
        phase_cnt <= phase_cnt + PH_W'(1);
      end
      if (launch) begin
        cycle_count <= '0;
        timed_out   <= 1'b0;
      end else begin
        if (cnt_inc) begin
          cycle_count <= cycle_count + CNT_W'(1);
        end
        if (fire_timeout) begin
          timed_out <= 1'b1;
        end
      end
    end
  end

  // All outputs decode from registered state, so reset zeroes them on its edge.
  assign core_reset = (state == RST);
  assign busy       = (state == RST) || (state == WAIT) || (state == RUN);
  assign done       = (state == DONE);
  assign go_contr   = run_en ? ~halted : '0;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench for core_run_ctrl: four parameterisations driven with
// directed vectors; run outcomes are checked when done rises.
module tb_core_run_ctrl;

  localparam logic [31:0] HW = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Defaults
  logic        def_start = 1'b0;
  logic [31:0] def_ir = '0;
  logic        def_core_reset, def_busy, def_done, def_to;
  logic [0:0]  def_go, def_halted;
  logic [31:0] def_cnt;

  // Two cores
  logic        dual_start = 1'b0;
  logic [63:0] dual_ir = '0;
  logic        dual_core_reset, dual_busy, dual_done, dual_to;
  logic [1:0]  dual_go, dual_halted;
  logic [31:0] dual_cnt;

  // Short watchdog
  logic        to_start = 1'b0;
  logic [31:0] to_ir = '0;
  logic        to_core_reset, to_busy, to_done, to_to;
  logic [0:0]  to_go, to_halted;
  logic [31:0] to_cnt;

  // Long reset, no go delay
  logic        rc_start = 1'b0;
  logic [31:0] rc_ir = '0;
  logic        rc_core_reset, rc_busy, rc_done, rc_to;
  logic [0:0]  rc_go, rc_halted;
  logic [31:0] rc_cnt;

  core_run_ctrl u_def (
    .clk(clk), .reset(reset), .start(def_start), .ir_in(def_ir),
    .core_reset(def_core_reset), .go_contr(def_go), .halted(def_halted),
    .busy(def_busy), .done(def_done), .timed_out(def_to), .cycle_count(def_cnt)
  );

  core_run_ctrl #(.N_CORES(2), .HALT_WORD(32'hFFFF_FFFF)) u_dual (
    .clk(clk), .reset(reset), .start(dual_start), .ir_in(dual_ir),
    .core_reset(dual_core_reset), .go_contr(dual_go), .halted(dual_halted),
    .busy(dual_busy), .done(dual_done), .timed_out(dual_to), .cycle_count(dual_cnt)
  );

  core_run_ctrl #(.TIMEOUT_CYCLES(20)) u_to (
    .clk(clk), .reset(reset), .start(to_start), .ir_in(to_ir),
    .core_reset(to_core_reset), .go_contr(to_go), .halted(to_halted),
    .busy(to_busy), .done(to_done), .timed_out(to_to), .cycle_count(to_cnt)
  );

  core_run_ctrl #(.RESET_CYCLES(3), .GO_DELAY(0)) u_rc (
    .clk(clk), .reset(reset), .start(rc_start), .ir_in(rc_ir),
    .core_reset(rc_core_reset), .go_contr(rc_go), .halted(rc_halted),
    .busy(rc_busy), .done(rc_done), .timed_out(rc_to), .cycle_count(rc_cnt)
  );

  typedef struct {
    int          unit;
    logic [1:0]  halted;
    logic        to;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_done(input int unit, input logic [1:0] h, input logic t,
                             input logic [31:0] c);
    exp_t e;
    e.unit = unit;
    e.halted = h;
    e.to = t;
    e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic score(input int unit, input logic [1:0] h, input logic t,
                       input logic [31:0] c, input logic [1:0] g);
    exp_t e;
    if (exp_q.size() == 0) begin
      total_cnt++;
      $display("FAIL sb_unexpected_done: got done on unit %0d, want no pending run", unit);
    end else begin
      e = exp_q.pop_front();
      check("sb_unit", unit, e.unit);
      check("sb_halted", h, e.halted);
      check("sb_timed_out", t, e.to);
      check("sb_cycle_count", c, e.cnt);
      check("sb_go_at_done", g, 2'b00);
    end
  endtask

  // Monitor: a run result is presented when done rises.
  logic def_done_q = 1'b0, dual_done_q = 1'b0, to_done_q = 1'b0, rc_done_q = 1'b0;
  always @(negedge clk) begin
    if (def_done === 1'b1 && !def_done_q)
      score(0, {1'b0, def_halted}, def_to, def_cnt, {1'b0, def_go});
    if (dual_done === 1'b1 && !dual_done_q)
      score(1, dual_halted, dual_to, dual_cnt, dual_go);
    if (to_done === 1'b1 && !to_done_q)
      score(2, {1'b0, to_halted}, to_to, to_cnt, {1'b0, to_go});
    if (rc_done === 1'b1 && !rc_done_q)
      score(3, {1'b0, rc_halted}, rc_to, rc_cnt, {1'b0, rc_go});
    def_done_q  <= (def_done === 1'b1);
    dual_done_q <= (dual_done === 1'b1);
    to_done_q   <= (to_done === 1'b1);
    rc_done_q   <= (rc_done === 1'b1);
  end

  initial begin
    tick(2);
    check("rst_outputs_def",
          {def_core_reset, def_go, def_halted, def_busy, def_done, def_to, def_cnt}, '0);
    check("rst_outputs_dual",
          {dual_core_reset, dual_go, dual_halted, dual_busy, dual_done, dual_to, dual_cnt}, '0);
    reset = 1'b0;
    tick(1);
    check("idle_busy", def_busy, 1'b0);

    // Defaults: single halt after 10 RUN cycles.
    def_start = 1'b1;
    tick(1);
    def_start = 1'b0;
    check("t1_core_reset_on", def_core_reset, 1'b1);
    check("t1_go_in_rst", def_go, 1'b0);
    tick(1);
    check("t1_core_reset_off", def_core_reset, 1'b0);
    check("t1_go_in_wait", def_go, 1'b0);
    check("t1_busy_wait", def_busy, 1'b1);
    tick(1);
    check("t1_go_run", def_go, 1'b1);
    check("t1_cnt_run_start", def_cnt, 0);
    tick(9);
    check("t1_cnt_9", def_cnt, 9);
    def_ir = HW;
    expect_done(0, 2'b01, 1'b0, 10);
    tick(1);
    def_ir = '0;
    check("t1_go_after_halt", def_go, 1'b0);
    check("t1_busy_done", def_busy, 1'b0);
    tick(3);
    check("t1_cnt_frozen", def_cnt, 10);
    check("t1_done_held", def_done, 1'b1);

    // Two cores halting at RUN cycles 5 and 9.
    dual_start = 1'b1;
    tick(1);
    dual_start = 1'b0;
    tick(2);
    check("t2_go_both", dual_go, 2'b11);
    tick(4);
    dual_ir[31:0] = HW;
    tick(1);
    dual_ir[31:0] = '0;
    check("t2_go_after_lane0", dual_go, 2'b10);
    check("t2_halted_lane0", dual_halted, 2'b01);
    check("t2_not_done", dual_done, 1'b0);
    tick(3);
    check("t2_lane0_sticky", dual_halted, 2'b01);
    dual_ir[63:32] = HW;
    expect_done(1, 2'b11, 1'b0, 9);
    tick(1);
    dual_ir[63:32] = '0;
    check("t2_done", dual_done, 1'b1);

    // Watchdog with IR never at the sentinel.
    to_start = 1'b1;
    tick(1);
    to_start = 1'b0;
    tick(2);
    tick(19);
    check("t3_cnt_19", to_cnt, 19);
    check("t3_busy_19", to_busy, 1'b1);
    expect_done(2, 2'b00, 1'b1, 20);
    tick(1);
    check("t3_timed_out", to_to, 1'b1);

    // Halt on exactly the watchdog edge; restart from DONE clears status.
    to_start = 1'b1;
    tick(1);
    to_start = 1'b0;
    check("t4_restart_clear",
          {to_core_reset, to_to, to_halted, to_cnt}, {1'b1, 1'b0, 1'b0, 32'd0});
    tick(2);
    tick(19);
    to_ir = HW;
    expect_done(2, 2'b01, 1'b0, 20);
    tick(1);
    to_ir = '0;
    check("t4_no_timeout", to_to, 1'b0);

    // Reset mid-RUN, then a clean run.
    def_start = 1'b1;
    tick(1);
    def_start = 1'b0;
    tick(2);
    tick(6);
    check("t5_cnt_6", def_cnt, 6);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t5_reset_outputs",
          {def_core_reset, def_go, def_halted, def_busy, def_done, def_to, def_cnt}, '0);
    def_start = 1'b1;
    tick(1);
    def_start = 1'b0;
    check("t5_core_reset_again", def_core_reset, 1'b1);
    tick(2);
    check("t5_go_again", def_go, 1'b1);
    tick(2);
    def_ir = HW;
    expect_done(0, 2'b01, 1'b0, 3);
    tick(1);
    def_ir = '0;

    // RESET_CYCLES=3, GO_DELAY=0, sentinel held during RST, start during RUN.
    rc_ir = HW;
    rc_start = 1'b1;
    tick(1);
    rc_start = 1'b0;
    check("t6_core_reset_c1", rc_core_reset, 1'b1);
    tick(1);
    check("t6_core_reset_c2", rc_core_reset, 1'b1);
    tick(1);
    check("t6_core_reset_c3", rc_core_reset, 1'b1);
    check("t6_no_halt_in_rst", rc_halted, 1'b0);
    tick(1);
    check("t6_run_entry", {rc_core_reset, rc_go, rc_halted, rc_busy}, 4'b0101);
    rc_ir = '0;
    tick(2);
    rc_start = 1'b1;
    tick(1);
    rc_start = 1'b0;
    check("t6_start_ignored", {rc_core_reset, rc_busy, rc_cnt}, {1'b0, 1'b1, 32'd3});
    tick(1);
    rc_ir = HW;
    expect_done(3, 2'b01, 1'b0, 5);
    tick(1);
    rc_ir = '0;

    tick(3);
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
